food_eat_ctrl: RTL and testbench

FOOD_EAT_CTRL -- requirements
Module: food_eat_ctrl

---
 rtl/snake_pkg.sv | 24 ++
 rtl/food_eat_ctrl_score_cnt.sv | 42 ++++
 rtl/food_eat_ctrl.sv | 78 +++++++
 tb/tb_food_eat_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared snake-game definitions: screen geometry, eat-controller states and
// the coordinate distance helper used for head/food overlap.
package snake_pkg;

  localparam int SCREEN_W    = 640;
  localparam int SCREEN_H    = 480;
  localparam int COORD_W     = 10;
  localparam int HIT_TOL_DEF = 10;

  typedef enum logic [1:0] {
    EAT_IDLE = 2'd0,
    EAT_GEN  = 2'd1,
    EAT_WAIT = 2'd2
  } eat_state_e;

  // |a-b| over an 11-bit signed difference; cannot wrap for 10-bit inputs.
  function automatic logic [COORD_W:0] abs_diff(input logic [COORD_W-1:0] a,
                                                input logic [COORD_W-1:0] b);
    logic signed [COORD_W:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    abs_diff = d[COORD_W] ? (COORD_W+1)'(-d) : (COORD_W+1)'(d);
  endfunction

endpackage

// File: rtl/food_eat_ctrl_score_cnt.sv
// Saturating score counter. FOOD_EAT_SCORE_BCD_EN selects packed BCD digits
// (saturating at all-9s); otherwise a plain binary count saturating at all-ones.
module score_cnt #(
  parameter int W = 14
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] score
);

`ifdef FOOD_EAT_SCORE_BCD_EN
  localparam int ND = W / 4;

  logic [ND-1:0][3:0] dig, nxt;
  logic [ND:0]        cy;

  assign dig   = score;
  assign cy[0] = 1'b1;

  // Carry ripples through every digit that is already 9.
  for (genvar i = 0; i < ND; i++) begin : g_dig
    assign nxt[i]  = cy[i] ? ((dig[i] == 4'd9) ? 4'd0 : dig[i] + 4'd1) : dig[i];
    assign cy[i+1] = cy[i] & (dig[i] == 4'd9);
  end

  // cy[ND] set means every digit is 9: saturated.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 score <= '0;
    else if (clear)            score <= '0;
    else if (inc && !cy[ND])   score <= nxt;
  end
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  score <= '0;
    else if (clear)             score <= '0;
    else if (inc && !(&score))  score <= score + 1'b1;
  end
`endif

endmodule

// File: rtl/food_eat_ctrl.sv
// Detects the snake head reaching the food, requests a new food position and a
// body extension, then locks out further eats until the generator settles.
// Score format is selected by FOOD_EAT_SCORE_BCD_EN (see score_cnt).
module food_eat_ctrl
  import snake_pkg::*;
#(
  parameter int HIT_TOL  = HIT_TOL_DEF,
  parameter int WAIT_CYC = 4,
  parameter int SCORE_W  = 14
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               step,
  input  logic [COORD_W-1:0] head_x,
  input  logic [COORD_W-1:0] head_y,
  input  logic [COORD_W-1:0] food_x,
  input  logic [COORD_W-1:0] food_y,
  output logic               gen,
  output logic               grow,
  output logic [SCORE_W-1:0] score,
  output logic               busy
);

  localparam int               CW  = $clog2(WAIT_CYC);
  localparam logic [COORD_W:0] TOL = (COORD_W+1)'(HIT_TOL);

  eat_state_e    state;
  logic [CW-1:0] wcnt;
  logic          hit;

  assign hit  = (abs_diff(head_x, food_x) < TOL) && (abs_diff(head_y, food_y) < TOL);
  assign busy = (state != EAT_IDLE);

  // step is only looked at in IDLE, so stale food coordinates during the
  // generator latency can never trigger a second eat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= EAT_IDLE;
      gen   <= 1'b0;
      grow  <= 1'b0;
      wcnt  <= '0;
    end else begin
      gen  <= 1'b0;
      grow <= 1'b0;
      if (clear) begin
        state <= EAT_IDLE;
        wcnt  <= '0;
      end else begin
        case (state)
          EAT_IDLE: if (step && hit) begin
            state <= EAT_GEN;
            gen   <= 1'b1;
            grow  <= 1'b1;
          end
          EAT_GEN: begin
            state <= EAT_WAIT;
            wcnt  <= CW'(WAIT_CYC - 1);
          end
          EAT_WAIT: begin
            if (wcnt == '0) state <= EAT_IDLE;
            else            wcnt  <= wcnt - 1'b1;
          end
          default: state <= EAT_IDLE;
        endcase
      end
    end
  end

  score_cnt #(.W(SCORE_W)) u_score (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .inc   ((state == EAT_GEN) && !clear),
    .score (score)
  );

endmodule

// File: tb/tb_food_eat_ctrl.sv
// Directed bench for food_eat_ctrl: a cycle-level behavioural model checked
// every cycle, plus literal expectations for the key scenarios.
module tb_food_eat_ctrl;

  localparam int HT = 10;
  localparam int WC = 4;
  localparam int W0 = 14;
  localparam int W1 = 4;

  logic clk = 1'b0, reset = 1'b0, clear = 1'b0, step = 1'b0;
  logic [9:0] hx = 10'd300, hy = 10'd200, fx = 10'd0, fy = 10'd0;
  logic gen0, grow0, busy0, gen1, grow1, busy1;
  logic [W0-1:0] score0;
  logic [W1-1:0] score1;

  int errors = 0, checks = 0;
  int m_left = 0, m_sc0 = 0, m_sc1 = 0;
  bit m_gen = 1'b0;
  int gcount = 0;
  bit cnt_en = 1'b0;

  always #5 clk = ~clk;

  food_eat_ctrl #(.HIT_TOL(HT), .WAIT_CYC(WC), .SCORE_W(W0)) u0 (
    .clk(clk), .reset(reset), .clear(clear), .step(step),
    .head_x(hx), .head_y(hy), .food_x(fx), .food_y(fy),
    .gen(gen0), .grow(grow0), .score(score0), .busy(busy0));

  food_eat_ctrl #(.HIT_TOL(HT), .WAIT_CYC(WC), .SCORE_W(W1)) u1 (
    .clk(clk), .reset(reset), .clear(clear), .step(step),
    .head_x(hx), .head_y(hy), .food_x(fx), .food_y(fy),
    .gen(gen1), .grow(grow1), .score(score1), .busy(busy1));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  function automatic int max_val(input int w);
`ifdef FOOD_EAT_SCORE_BCD_EN
    max_val = 10 ** (w / 4) - 1;
`else
    max_val = (1 << w) - 1;
`endif
  endfunction

  function automatic logic [31:0] enc(input int v);
    logic [31:0] r;
    int t;
    r = 0;
    t = v;
`ifdef FOOD_EAT_SCORE_BCD_EN
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
`else
    r = 32'(t);
`endif
    enc = r;
  endfunction

  function automatic bit m_hit();
    int dx, dy;
    dx = int'(hx) - int'(fx);
    dy = int'(hy) - int'(fy);
    if (dx < 0) dx = -dx;
    if (dy < 0) dy = -dy;
    m_hit = (dx < HT) && (dy < HT);
  endfunction

  // Model: an eat makes the block busy for 1+WC cycles, gen in the first one,
  // and the score rises by one (saturating) when that first cycle ends.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_left = 0; m_gen = 1'b0; m_sc0 = 0; m_sc1 = 0;
    end else if (clear) begin
      m_left = 0; m_gen = 1'b0; m_sc0 = 0; m_sc1 = 0;
    end else if (m_left > 0) begin
      if (m_gen) begin
        if (m_sc0 < max_val(W0)) m_sc0++;
        if (m_sc1 < max_val(W1)) m_sc1++;
      end
      m_left--;
      m_gen = 1'b0;
    end else if (step && m_hit()) begin
      m_gen  = 1'b1;
      m_left = 1 + WC;
    end
  end

  always @(negedge clk) begin
    chk("gen0",   32'(gen0),   32'(m_gen));
    chk("grow0",  32'(grow0),  32'(m_gen));
    chk("busy0",  32'(busy0),  32'(m_left > 0));
    chk("score0", 32'(score0), enc(m_sc0));
    chk("gen1",   32'(gen1),   32'(m_gen));
    chk("busy1",  32'(busy1),  32'(m_left > 0));
    chk("score1", 32'(score1), enc(m_sc1));
    if (cnt_en && gen0) gcount++;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic eat();
    step = 1'b1; cyc(1); step = 1'b0; cyc(6);
  endtask

  initial begin
    #2 reset = 1'b1;
    #2;
    chk("rst_gen", 32'(gen0), 32'd0);
    chk("rst_score", 32'(score0), 32'd0);
    chk("rst_busy", 32'(busy0), 32'd0);
    cyc(2);
    reset = 1'b0;
    cyc(2);

    // Basic eat: gen one cycle after the step edge, score follows.
    fx = 10'd305; fy = 10'd195;
    step = 1'b1; cyc(1); step = 1'b0;
    chk("eat_gen", 32'(gen0), 32'd1);
    chk("eat_grow", 32'(grow0), 32'd1);
    cyc(1);
    chk("eat_gen_off", 32'(gen0), 32'd0);
    chk("eat_score", 32'(score0), enc(1));
    chk("eat_busy", 32'(busy0), 32'd1);
    cyc(4);
    chk("eat_idle", 32'(busy0), 32'd0);
    cyc(1);

    // Tolerance boundaries on both axes and signs.
    fx = 10'd310; fy = 10'd200;
    step = 1'b1; cyc(1); step = 1'b0;
    chk("tol_x10", 32'(gen0), 32'd0);
    cyc(1);
    fx = 10'd309;
    step = 1'b1; cyc(1); step = 1'b0;
    chk("tol_x9", 32'(gen0), 32'd1);
    cyc(6);
    fx = 10'd300; fy = 10'd190;
    step = 1'b1; cyc(1); step = 1'b0;
    chk("tol_yneg10", 32'(gen0), 32'd0);
    fy = 10'd191; eat();
    fx = 10'd290; fy = 10'd200; eat();
    fx = 10'd291; eat();

    // Step held high with a persistent hit: one gen per busy window.
    fx = 10'd300; fy = 10'd200;
    gcount = 0; cnt_en = 1'b1;
    step = 1'b1; cyc(6);
    cnt_en = 1'b0;
    chk("hold_one_gen", 32'(gcount), 32'd1);
    cyc(8); step = 1'b0; cyc(6);

    // clear beats a simultaneous hit.
    clear = 1'b1; cyc(1); clear = 1'b0;
    repeat (5) eat();
    chk("score5", 32'(score0), enc(5));
    clear = 1'b1; step = 1'b1; cyc(1); clear = 1'b0; step = 1'b0;
    chk("clr_gen", 32'(gen0), 32'd0);
    chk("clr_grow", 32'(grow0), 32'd0);
    chk("clr_score", 32'(score0), 32'd0);
    chk("clr_busy", 32'(busy0), 32'd0);

    // Saturation on the narrow instance.
    repeat (16) eat();
    chk("sat_score", 32'(score1), enc(max_val(W1)));
    step = 1'b1; cyc(1); step = 1'b0;
    chk("sat_gen", 32'(gen1), 32'd1);
    cyc(1);
    chk("sat_hold", 32'(score1), enc(max_val(W1)));
    cyc(5);

    // Reset between edges mid-WAIT.
    step = 1'b1; cyc(1); step = 1'b0; cyc(2);
    #3 reset = 1'b1;
    #1;
    chk("arst_gen", 32'(gen0), 32'd0);
    chk("arst_busy", 32'(busy0), 32'd0);
    chk("arst_score", 32'(score0), 32'd0);
    cyc(2);
    reset = 1'b0;
    gcount = 0; cnt_en = 1'b1;
    cyc(8);
    cnt_en = 1'b0;
    chk("arst_no_gen", 32'(gcount), 32'd0);
    step = 1'b1; cyc(1); step = 1'b0;
    chk("arst_first_step", 32'(gen0), 32'd1);
    cyc(6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
